audio_dac_serializer: RTL

Downstream consumer of the tone generator's sample stream: accepts left/right 32-bit PCM pairs through the `write_audio_out` / `audio_out_allowed` handshake and buffers them in a small FIFO. It shifts them out MSB-first on `AUD_DACDAT` in left-justified format, clocked by the codec-mastered `AUD_BCLK` / `AUD_DACLRCK`. It replaces the DAC half of the audio controller so the tone path can drive the codec directly from the `CLOCK_50` domain.

---
 rtl/audio_dac_serializer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/audio_dac_serializer.sv
// rtl/audio_dac_serializer.sv - left-justified serial DAC feeder with sample-pair FIFO
//
// Purpose: buffers {left,right} PCM pairs from the tone path and shifts them
// out MSB-first on AUD_DACDAT, framed by the codec-mastered BCLK/LRCK.
//
// Ports:
//   CLOCK_50                 system clock, all logic on rising edge
//   reset                    synchronous active-high reset
//   clear_audio_out_memory   synchronous FIFO flush
//   left/right_channel_audio_out  sample pair to enqueue
//   write_audio_out          push request (taken only when audio_out_allowed)
//   AUD_BCLK, AUD_DACLRCK    codec clocks, asynchronous (LRCK high = left)
//   audio_out_allowed        FIFO not full
//   dac_fifo_space           free FIFO entries
//   underrun                 1-cycle pulse when a frame starts with FIFO empty
//   AUD_DACDAT               serial DAC data
module audio_dac_serializer #(
   parameter int FIFO_DEPTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                          CLOCK_50,
   input  logic                          reset,
   input  logic                          clear_audio_out_memory,
   input  logic [DATA_WIDTH-1:0]         left_channel_audio_out,
   input  logic [DATA_WIDTH-1:0]         right_channel_audio_out,
   input  logic                          write_audio_out,
   input  logic                          AUD_BCLK,
   input  logic                          AUD_DACLRCK,
   output logic                          audio_out_allowed,
   output logic [$clog2(FIFO_DEPTH):0]   dac_fifo_space,
   output logic                          underrun,
   output logic                          AUD_DACDAT
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_LEFT, S_RIGHT} state_t;

   // Two synchroniser flops plus one history flop per codec clock. These are
   // deliberately not reset: clearing them while LRCK is high would fake a
   // rising edge and start a frame in the middle of the left half.
   logic [2:0] bclk_sync;
   logic [2:0] lrck_sync;
   logic       bclk_fall;
   logic       lrck_rise;
   logic       lrck_fall;

   always_ff @(posedge CLOCK_50) begin
      bclk_sync <= {bclk_sync[1:0], AUD_BCLK};
      lrck_sync <= {lrck_sync[1:0], AUD_DACLRCK};
   end

   assign bclk_fall = bclk_sync[2] & ~bclk_sync[1];
   assign lrck_rise = ~lrck_sync[2] & lrck_sync[1];
   assign lrck_fall = lrck_sync[2] & ~lrck_sync[1];

   // Sample-pair FIFO
   logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [CW-1:0]           count;
   logic [2*DATA_WIDTH-1:0] head;
   logic                    push;
   logic                    pop;

   assign audio_out_allowed = (count != CW'(FIFO_DEPTH));
   assign dac_fifo_space    = CW'(FIFO_DEPTH) - count;
   assign head              = mem[rd_ptr];

   // Full is judged on the registered count, so a pop in the same cycle does
   // not make room for a push to a full FIFO.
   assign push = write_audio_out & audio_out_allowed & ~clear_audio_out_memory;
   assign pop  = lrck_rise & (count != '0);

   always_ff @(posedge CLOCK_50) begin
      if (push) begin
         mem[wr_ptr] <= {left_channel_audio_out, right_channel_audio_out};
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset || clear_audio_out_memory) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Serializer FSM
   state_t state;
   state_t state_next;
   logic   load_left;
   logic   load_right;

   always_ff @(posedge CLOCK_50) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // IDLE waits for a rising LRCK so the first word after reset is always left.
   // Any LRCK edge restarts the word regardless of how many bits went out.
   always_comb begin
      state_next = state;
      load_left  = 1'b0;
      load_right = 1'b0;
      case (state)
         S_IDLE: begin
            if (lrck_rise) begin
               state_next = S_LEFT;
               load_left  = 1'b1;
            end
         end
         S_LEFT, S_RIGHT: begin
            if (lrck_rise) begin
               state_next = S_LEFT;
               load_left  = 1'b1;
            end else if (lrck_fall) begin
               state_next = S_RIGHT;
               load_right = 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Shift register is zero-filled, so once all bits of a word have gone out
   // the line stays low until the next LRCK edge reloads it.
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] right_hold;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         shift_reg  <= '0;
         right_hold <= '0;
         underrun   <= 1'b0;
      end else begin
         underrun <= lrck_rise & (count == '0);
         if (load_left) begin
            shift_reg  <= pop ? head[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
            right_hold <= pop ? head[DATA_WIDTH-1:0] : '0;
         end else if (load_right) begin
            shift_reg <= right_hold;
         end else if (bclk_fall && state != S_IDLE) begin
            shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
         end
      end
   end

   assign AUD_DACDAT = shift_reg[DATA_WIDTH-1];

endmodule
